// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_ctrl
// Desc   : One-bit-per-clock UART frame sequencer (start, data LSB first,
//          optional parity, one or two stop bits) with ready/busy handshake.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_ctrl #(
  parameter int Data_Len = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [Data_Len-1:0] P_DATA,
  input  logic                Data_Valid,
  input  logic                PAR_EN,
  input  logic                PAR_TYP,
  input  logic                STOP2,
  output logic                TX_OUT,
  output logic                TX_Ready,
  output logic                Busy,
  output logic                Frame_Done
);

  localparam int c_cnt_w = $clog2(Data_Len + 1);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(Data_Len - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;

  logic [2:0]          r_state;
  logic [c_cnt_w-1:0]  r_bit_cnt;
  logic                r_stop_cnt;
  logic [Data_Len-1:0] r_data;
  logic                r_par_en;
  logic                r_parity;
  logic                r_stop2;
  logic                r_tx_out;
  logic                r_busy;
  logic                r_frame_done;

  logic [2:0]          w_next_state;
  logic [c_cnt_w-1:0]  w_bit_cnt_nxt;
  logic                w_stop_cnt_nxt;
  logic                w_last_stop;
  logic                w_accept;
  logic                w_data_bit;
  logic                w_tx_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;

  // Ready depends only on state and stop counter, never on Data_Valid.
  assign w_last_stop = (r_state == c_STOP) && (r_stop_cnt == r_stop2);
  assign TX_Ready    = (r_state == c_IDLE) || w_last_stop;
  assign w_accept    = Data_Valid && TX_Ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= c_IDLE;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_data       <= '0;
      r_par_en     <= 1'b0;
      r_parity     <= 1'b0;
      r_stop2      <= 1'b0;
      r_tx_out     <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_stop_cnt   <= w_stop_cnt_nxt;
      r_tx_out     <= w_tx_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_done_nxt;
      if (w_accept) begin
        r_data   <= P_DATA;
        r_par_en <= PAR_EN;
        r_parity <= PAR_TYP ? ~^P_DATA : ^P_DATA;
        r_stop2  <= STOP2;
      end
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    case (r_state)
      c_IDLE: begin
        if (w_accept) w_next_state = c_START;
      end
      c_START: begin
        w_next_state  = c_DATA;
        w_bit_cnt_nxt = '0;
      end
      c_DATA: begin
        if (r_bit_cnt == c_last_bit) begin
          w_next_state   = r_par_en ? c_PARITY : c_STOP;
          w_stop_cnt_nxt = 1'b0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      c_PARITY: begin
        w_next_state   = c_STOP;
        w_stop_cnt_nxt = 1'b0;
      end
      c_STOP: begin
        if (w_last_stop) w_next_state = w_accept ? c_START : c_IDLE;
        else             w_stop_cnt_nxt = 1'b1;
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they can be registered.
  always_comb begin
    w_data_bit = 1'b0;
    for (int i = 0; i < Data_Len; i++) begin
      if (w_bit_cnt_nxt == c_cnt_w'(i)) w_data_bit = r_data[i];
    end
    case (w_next_state)
      c_START:  w_tx_nxt = 1'b0;
      c_DATA:   w_tx_nxt = w_data_bit;
      c_PARITY: w_tx_nxt = r_parity;
      default:  w_tx_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_next_state != c_IDLE);
    w_done_nxt = (w_next_state == c_STOP) && (w_stop_cnt_nxt == r_stop2);
  end

  assign TX_OUT     = r_tx_out;
  assign Busy       = r_busy;
  assign Frame_Done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_ctrl
// Desc   : Self-checking bench for uart_tx_ctrl: directed frame table, corner
//          sequences and random traffic against a frame-queue line model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_tx_ctrl;

  localparam int DL = 8;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic [DL-1:0] pd  = '0;
  logic          dv  = 1'b0;
  logic          pe  = 1'b0;
  logic          pt  = 1'b0;
  logic          s2  = 1'b0;
  logic          TX_OUT, TX_Ready, Busy, Frame_Done;

  int n_tests = 0;
  int n_fail  = 0;

  // Bits still to appear on the line; element 0 is the bit of the current cycle.
  bit mq[$];

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    logic       stop2;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  vec_t vecs[8];

  uart_tx_ctrl #(.Data_Len(DL)) dut (
    .CLK       (CLK),
    .RST       (rst),
    .P_DATA    (pd),
    .Data_Valid(dv),
    .PAR_EN    (pe),
    .PAR_TYP   (pt),
    .STOP2     (s2),
    .TX_OUT    (TX_OUT),
    .TX_Ready  (TX_Ready),
    .Busy      (Busy),
    .Frame_Done(Frame_Done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_frame(input logic [DL-1:0] d, input bit en,
                                     input bit odd, input bit two);
    int ones;
    ones = $countones(d);
    mq.push_back(1'b0);
    for (int i = 0; i < DL; i++) mq.push_back(d[i]);
    if (en) mq.push_back(odd ? (ones % 2 == 0) : (ones % 2 == 1));
    mq.push_back(1'b1);
    if (two) mq.push_back(1'b1);
  endfunction

  task automatic check_model();
    check("model_tx",    TX_OUT,     (mq.size() > 0) ? mq[0] : 1'b1);
    check("model_busy",  Busy,       mq.size() > 0);
    check("model_done",  Frame_Done, mq.size() == 1);
    check("model_ready", TX_Ready,   mq.size() <= 1);
  endtask

  // One clock: advance the line model with the inputs seen at the edge,
  // then compare all outputs mid-cycle.
  task automatic tick();
    bit ready_pre;
    ready_pre = (mq.size() <= 1);
    @(posedge CLK);
    if (rst) begin
      mq.delete();
    end else begin
      if (mq.size() > 0) void'(mq.pop_front());
      if (dv && ready_pre) push_frame(pd, pe, pt, s2);
    end
    @(negedge CLK);
    check_model();
  endtask

  task automatic run_vec(input vec_t v);
    logic exp;
    pd = v.data; pe = v.par_en; pt = v.par_typ; s2 = v.stop2; dv = 1'b1;
    tick();
    dv = 1'b0;
    for (int c = 0; c < v.exp_len; c++) begin
      if (c == 0)                        exp = 1'b0;
      else if (c <= DL)                  exp = v.data[c-1];
      else if (v.par_en && c == DL + 1)  exp = v.exp_par;
      else                               exp = 1'b1;
      check("vec_tx", TX_OUT, exp);
      check("vec_busy", Busy, 1'b1);
      check("vec_done", Frame_Done, c == v.exp_len - 1);
      check("vec_ready", TX_Ready, c == v.exp_len - 1);
      pd = ~pd; pt = ~pt; pe = ~pe; s2 = ~s2;
      tick();
    end
    check("vec_end_busy", Busy, 1'b0);
    check("vec_end_tx", TX_OUT, 1'b1);
  endtask

  initial begin
    int n_done;
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 10};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 11};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 11};
    vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 11};
    vecs[4] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 12};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 12};
    vecs[6] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 11};
    vecs[7] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 11};

    rst = 1'b1;
    tick();
    tick();
    check("reset_tx", TX_OUT, 1'b1);
    check("reset_busy", Busy, 1'b0);
    check("reset_ready", TX_Ready, 1'b1);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: Data_Valid held across the final stop bit.
    n_done = 0;
    pd = 8'h3C; pe = 1'b0; pt = 1'b0; s2 = 1'b0; dv = 1'b1;
    tick();
    pd = 8'hC3;
    for (int c = 0; c < 10; c++) begin
      if (Frame_Done) n_done++;
      tick();
    end
    check("b2b_start_tx", TX_OUT, 1'b0);
    check("b2b_start_busy", Busy, 1'b1);
    dv = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (Frame_Done) n_done++;
      tick();
    end
    check("b2b_done_twice", n_done == 2, 1'b1);
    check("b2b_idle", Busy, 1'b0);

    // Data_Valid pulse during DATA must be dropped.
    pd = 8'h55; dv = 1'b1;
    tick();
    dv = 1'b0;
    repeat (3) tick();
    pd = 8'hAA; dv = 1'b1;
    tick();
    dv = 1'b0;
    repeat (12) tick();
    check("drop_idle", Busy, 1'b0);

    // Reset during data bit 3 aborts the frame.
    pd = 8'hA5; pe = 1'b1; dv = 1'b1;
    tick();
    dv = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("abort_tx", TX_OUT, 1'b1);
    check("abort_busy", Busy, 1'b0);
    check("abort_done", Frame_Done, 1'b0);
    dv = 1'b1;
    tick();
    check("rst_prio_busy", Busy, 1'b0);
    rst = 1'b0; dv = 1'b0;
    tick();
    run_vec(vecs[0]);

    // Random traffic against the line model.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      dv  = ($urandom_range(0, 2) == 0);
      pd  = DL'($urandom);
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      s2  = 1'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that sequences one serial frame per accepted byte: start bit, `Data_Len` data bits LSB first, optional parity bit, and one or two stop bits. It sits between the host-side parallel data interface and the TX line. It computes parity internally, serialises the latched word, and exposes a ready/busy handshake so the host can stream frames back-to-back. `CLK` is the bit clock: one cycle equals one bit time.

## Interface
- `Data_Len`, 8: data bits per frame, ≥ 1.
- `CLK` input 1: bit clock; all logic is rising-edge.
- `RST` input 1: synchronous, active-high reset.
- `P_DATA` input `Data_Len`: parallel word; sampled only on acceptance.
- `Data_Valid` input 1: host offers `P_DATA`.
- `PAR_EN` input 1: 1 inserts a parity bit; sampled on acceptance.
- `PAR_TYP` input 1: 1 selects odd parity, 0 selects even; sampled on acceptance.
- `STOP2` input 1: 1 sends two stop bits, 0 sends one; sampled on acceptance.
- `TX_OUT` output 1: serial line, idle high.
- `TX_Ready` output 1: combinational; high in IDLE and in the final stop-bit cycle.
- `Busy` output 1: registered; high while a frame is on the line.
- `Frame_Done` output 1: registered one-cycle pulse, coincident with the final stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance occurs when `Data_Valid && TX_Ready` at a rising edge.
  - On acceptance, latch `P_DATA`, `PAR_EN`, `PAR_TYP` and `STOP2` into internal registers.
  - Compute the parity bit from the latched data:
    - odd: `~^data`, so the data plus parity has an odd number of ones;
    - even: `^data`.
- `Data_Valid` while `TX_Ready` = 0 is ignored and the word is dropped; there is no queueing.
- Input changes after acceptance have no effect on the frame in flight.
- State transitions:
  - IDLE → START on acceptance.
  - START → DATA.
  - DATA spends `Data_Len` cycles; a bit counter runs 0..`Data_Len`-1 and `TX_OUT` = data[counter].
  - DATA → PARITY if the latched `PAR_EN` = 1, else DATA → STOP.
  - PARITY → STOP.
  - STOP spends 1 cycle, or 2 cycles if the latched `STOP2` = 1.
  - At the end of STOP: go to START if an acceptance occurred in the final stop cycle, else go to IDLE.
- `TX_OUT` per state: IDLE = 1, START = 0, DATA = data bit, PARITY = parity bit, STOP = 1.
- Bit counter width is `$clog2(Data_Len+1)` and it is cleared on entry to DATA. The stop counter is 1 bit.
- `Busy` = 1 in START, DATA, PARITY and STOP; 0 in IDLE.

## Timing
- Reset values: state IDLE, `TX_OUT` = 1, `Busy` = 0, `Frame_Done` = 0, `TX_Ready` = 1, all counters and latches 0.
- `RST` mid-frame aborts the frame. The next cycle is IDLE with `TX_OUT` = 1, and no `Frame_Done` is produced. Reset has priority over acceptance in the same cycle.
- Latency: acceptance at edge k puts the start bit on `TX_OUT` during cycle k+1.
- Frame length L = 1 + `Data_Len` + `PAR_EN` + (1 + `STOP2`) cycles.
  - Example: `Data_Len` = 8, no parity, one stop bit gives L = 10.
  - Example: `Data_Len` = 8, parity, two stop bits gives L = 12.
- Back-to-back: acceptance during the final stop cycle makes the next start bit follow immediately, with no idle gap. Throughput is one frame per L cycles.
- `Frame_Done` is high exactly during the last stop-bit cycle, once per completed frame.
- `TX_OUT` and `Busy` are registered and glitch-free. `TX_Ready` is combinational from state and the stop counter, with no combinational path from `Data_Valid`.

## Test plan
- Reset, then 0xA5, `PAR_EN` = 0, `STOP2` = 0 → `TX_OUT` = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; `Frame_Done` pulses in cycle 10; `Busy` is high for cycles 1–10 and then low.
- 0xA5, `PAR_EN` = 1: with `PAR_TYP` = 0 (even) the parity bit is 0; with `PAR_TYP` = 1 (odd) the parity bit is 1. Repeat with 0x07: the even parity bit is 1.
- 0xFF, `PAR_EN` = 1, `STOP2` = 1 → 12-cycle frame ending in two 1 stop bits; `TX_Ready` is high only in the second stop cycle.
- `Data_Valid` held high with 0x3C then 0xC3 → the second start bit immediately follows the first frame's stop bit; `Frame_Done` pulses once per frame. A `Data_Valid` pulse mid-frame (in DATA) is dropped and the frame is unchanged.
- `RST` asserted during data bit 3 → `TX_OUT` = 1, `Busy` = 0, no `Frame_Done`. A new frame accepted after reset transmits correctly.
- `P_DATA` and `PAR_TYP` toggled every cycle after acceptance → transmitted bits and parity match the values latched at acceptance.
